// File: rtl/iiitb_cps.sv
// Parking gate controller: car detect -> timed password window -> go/stop LEDs + 2-digit display.
// Latency: outputs registered from current state, visible one clock after each state change.
// Backpressure: none; sensors and keypad are sampled level inputs every clock.
module iiitb_cps #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [1:0]  PASS_1      = 2'b01,
  parameter logic [1:0]  PASS_2      = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  localparam logic [31:0] WAIT_LIM = 32'(WAIT_CYCLES);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_G     = 7'h02;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_P     = 7'h0C;

  state_t      state, state_nxt;
  logic [31:0] wait_cnt;
  logic        pass_ok;

  assign pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      // Counter only runs while waiting, so every new car starts a fresh window.
      wait_cnt <= (state == WAIT_PASSWORD) ? wait_cnt + 32'd1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sensor_entrance) state_nxt = WAIT_PASSWORD;
      end
      WAIT_PASSWORD: begin
        if (wait_cnt > WAIT_LIM) state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
      end
      WRONG_PASS: begin
        if (pass_ok) state_nxt = RIGHT_PASS;
      end
      RIGHT_PASS: begin
        // A second car arriving while the first leaves is treated as tailgating.
        if (sensor_entrance && sensor_exit) state_nxt = STOP;
        else if (sensor_exit)               state_nxt = IDLE;
      end
      STOP: begin
        if (pass_ok) state_nxt = RIGHT_PASS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= SEG_BLANK;
      HEX_2     <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b0;
          HEX_1     <= SEG_BLANK;
          HEX_2     <= SEG_BLANK;
        end
        WAIT_PASSWORD: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b1;
          HEX_1     <= SEG_E;
          HEX_2     <= SEG_N;
        end
        WRONG_PASS: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= ~RED_LED;
          HEX_1     <= SEG_E;
          HEX_2     <= SEG_E;
        end
        RIGHT_PASS: begin
          GREEN_LED <= ~GREEN_LED;
          RED_LED   <= 1'b0;
          HEX_1     <= SEG_G;
          HEX_2     <= SEG_O;
        end
        STOP: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= ~RED_LED;
          HEX_1     <= SEG_S;
          HEX_2     <= SEG_P;
        end
        default: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b0;
          HEX_1     <= SEG_BLANK;
          HEX_2     <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_cps.sv
// Directed bench for iiitb_cps: walks the gate through every state and checks LEDs/digits each clock.
// Inputs driven and outputs sampled on the falling edge.
module tb_iiitb_cps;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int vectors = 0;
  int miscompares = 0;

  iiitb_cps dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #5 clk = ~clk;

  // Expected output words {G, R, HEX_1, HEX_2}
  localparam logic [15:0] BLANK = {1'b0, 1'b0, 7'h7F, 7'h7F};
  localparam logic [15:0] EN_R1 = {1'b0, 1'b1, 7'h06, 7'h2B};
  localparam logic [15:0] EE_R0 = {1'b0, 1'b0, 7'h06, 7'h06};
  localparam logic [15:0] EE_R1 = {1'b0, 1'b1, 7'h06, 7'h06};
  localparam logic [15:0] GO_G0 = {1'b0, 1'b0, 7'h02, 7'h40};
  localparam logic [15:0] GO_G1 = {1'b1, 1'b0, 7'h02, 7'h40};
  localparam logic [15:0] SP_R0 = {1'b0, 1'b0, 7'h12, 7'h0C};
  localparam logic [15:0] SP_R1 = {1'b0, 1'b1, 7'h12, 7'h0C};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] expected);
    logic [15:0] observed;
    observed = {GREEN_LED, RED_LED, HEX_1, HEX_2};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    password_1      = 2'd0;
    password_2      = 2'd0;

    // Reset held five clocks
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset", BLANK);
    reset_n = 1'b1;
    tick();
    check("idle_1", BLANK);
    tick();
    tick();
    check("idle_3", BLANK);

    // Wrong password: entrance seen, five clocks of "En", then "EE" with red blinking
    sensor_entrance = 1'b1;
    tick();
    check("a_entry", BLANK);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // Correct code flashed mid-wait and withdrawn before the check clock
      if (i == 1) begin password_1 = 2'd1; password_2 = 2'd2; end
      if (i == 3) begin password_1 = 2'd0; password_2 = 2'd0; end
      tick();
      check("a_wait", EN_R1);
    end
    tick();
    check("a_wrong_0", EE_R0);
    tick();
    check("a_wrong_1", EE_R1);
    tick();
    check("a_wrong_2", EE_R0);
    password_1 = 2'd1;
    password_2 = 2'd2;
    tick();
    check("a_wrong_3", EE_R1);
    tick();
    check("a_right_0", GO_G1);
    tick();
    check("a_right_1", GO_G0);
    tick();
    check("a_right_2", GO_G1);

    // Car leaves: back to idle, display blanks one clock after the state change
    sensor_exit = 1'b1;
    tick();
    check("exit_0", GO_G0);
    sensor_exit = 1'b0;
    tick();
    check("exit_1", BLANK);
    tick();
    check("exit_2", BLANK);

    // Correct password already present: straight to "GO" after the window
    sensor_entrance = 1'b1;
    tick();
    check("b_entry", BLANK);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_wait", EN_R1);
    end
    tick();
    check("b_right_0", GO_G1);
    tick();
    check("b_right_1", GO_G0);

    // Entrance alone keeps RIGHT_PASS; entrance plus exit goes to STOP
    sensor_entrance = 1'b1;
    tick();
    check("b_ent_only", GO_G1);
    sensor_exit = 1'b1;
    tick();
    check("stop_entry", GO_G0);
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    password_1      = 2'd0;
    password_2      = 2'd0;
    tick();
    check("stop_0", SP_R1);
    tick();
    check("stop_1", SP_R0);
    tick();
    check("stop_2", SP_R1);
    password_1 = 2'd1;
    password_2 = 2'd2;
    tick();
    check("stop_3", SP_R0);
    tick();
    check("stop_right", GO_G1);

    // Leave, then async reset in the middle of a wait window
    sensor_exit = 1'b1;
    tick();
    check("e_exit_0", GO_G0);
    sensor_exit = 1'b0;
    tick();
    check("e_exit_1", BLANK);
    sensor_entrance = 1'b1;
    tick();
    check("e_entry", BLANK);
    sensor_entrance = 1'b0;
    tick();
    check("e_wait_0", EN_R1);
    tick();
    check("e_wait_1", EN_R1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", BLANK);
    @(negedge clk);
    check("reset_hold", BLANK);
    reset_n = 1'b1;

    // Window must be a full five clocks again after reset
    sensor_entrance = 1'b1;
    tick();
    check("f_entry", BLANK);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("f_wait", EN_R1);
    end
    tick();
    check("f_right", GO_G1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
